// File: rtl/fp21_pack.sv
// FP21 normalise/round/pack pipeline: {sign, signed exp, unnormalised magnitude} -> packed FP21.
// Three register stages (LZC, normalise, round/pack); the pipe stalls as a whole on output backpressure.
module fp21_pack #(
  parameter int unsigned FRAC_W   = 12,
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned BIAS     = 127,
  parameter int unsigned EXP_IN_W = 10,
  parameter int unsigned MAG_W    = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_IN_W-1:0]       in_exp,
  input  logic [MAG_W-1:0]          in_mag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_fp,
  output logic                      out_overflow,
  output logic                      out_underflow
);

  localparam int unsigned P_W      = $clog2(MAG_W);
  localparam int unsigned E_W      = EXP_IN_W + 2;
  localparam int unsigned TAIL_W   = MAG_W - 1;
  localparam int unsigned STICKY_W = TAIL_W - FRAC_W - 1;
  localparam int unsigned EXP_MAX  = (1 << EXP_W) - 1;

  function automatic logic [P_W-1:0] lead_one(input logic [MAG_W-1:0] m);
    lead_one = '0;
    for (int unsigned i = 0; i < MAG_W; i++) begin
      if (m[i]) lead_one = P_W'(i);
    end
  endfunction

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage 1: capture operands and locate the leading one
  logic                r_s1_valid;
  logic                r_s1_sign;
  logic                r_s1_zero;
  logic [EXP_IN_W-1:0] r_s1_exp;
  logic [MAG_W-1:0]    r_s1_mag;
  logic [P_W-1:0]      r_s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mag   <= '0;
      r_s1_p     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_zero <= (in_mag == '0);
        r_s1_exp  <= in_exp;
        r_s1_mag  <= in_mag;
        r_s1_p    <= lead_one(in_mag);
      end
    end
  end

  // Stage 2: the implicit leading one is shifted to the MSB and dropped from the tail
  logic [P_W-1:0]    w_s2_shift;
  logic [TAIL_W-1:0] w_s2_tail;
  logic [E_W-1:0]    w_s2_e;

  assign w_s2_shift = P_W'(MAG_W - 1) - r_s1_p;
  assign w_s2_tail  = TAIL_W'(r_s1_mag << w_s2_shift);
  assign w_s2_e     = {{(E_W-EXP_IN_W){r_s1_exp[EXP_IN_W-1]}}, r_s1_exp}
                    + E_W'(r_s1_p) - E_W'(MAG_W - 2);

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic              r_s2_zero;
  logic [E_W-1:0]    r_s2_e;
  logic [FRAC_W-1:0] r_s2_frac;
  logic              r_s2_guard;
  logic              r_s2_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_e      <= '0;
      r_s2_frac   <= '0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_zero   <= r_s1_zero;
        r_s2_e      <= w_s2_e;
        r_s2_frac   <= w_s2_tail[TAIL_W-1 -: FRAC_W];
        r_s2_guard  <= w_s2_tail[STICKY_W];
        r_s2_sticky <= |w_s2_tail[STICKY_W-1:0];
      end
    end
  end

  // Stage 3: round to nearest even, then range-check the rounded exponent
  logic              w_s3_inc;
  logic [FRAC_W:0]   w_s3_sum;
  logic [E_W-1:0]    w_s3_biased;
  logic              w_s3_unf;
  logic              w_s3_ovf;

  assign w_s3_inc    = r_s2_guard && (r_s2_sticky || r_s2_frac[0]);
  assign w_s3_sum    = {1'b0, r_s2_frac} + (FRAC_W+1)'(w_s3_inc);
  assign w_s3_biased = r_s2_e + E_W'(w_s3_sum[FRAC_W]) + E_W'(BIAS);
  assign w_s3_unf    = r_s2_zero || w_s3_biased[E_W-1] || (w_s3_biased == '0);
  assign w_s3_ovf    = !w_s3_biased[E_W-1] && (w_s3_biased >= E_W'(EXP_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_fp        <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        if (w_s3_unf) begin
          out_fp        <= {r_s2_sign, {(EXP_W+FRAC_W){1'b0}}};
          out_overflow  <= 1'b0;
          out_underflow <= 1'b1;
        end else if (w_s3_ovf) begin
          out_fp        <= {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          out_overflow  <= 1'b1;
          out_underflow <= 1'b0;
        end else begin
          out_fp        <= {r_s2_sign, w_s3_biased[EXP_W-1:0], w_s3_sum[FRAC_W-1:0]};
          out_overflow  <= 1'b0;
          out_underflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp21_pack.sv
// Scoreboard bench for fp21_pack: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_fp21_pack;

  typedef struct packed {
    logic [20:0] fp;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [25:0] in_mag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] out_fp;
  logic        out_overflow;
  logic        out_underflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  int   rdy_mode = 0;
  int   rdy_cyc  = 0;
  exp_t sb_q[$];

  fp21_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp(out_fp), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: round the value mag*2^(exp-24) to a 13-bit significand by integer division
  function automatic exp_t model(input logic s, input int e_in, input longint m);
    exp_t   r;
    int     p;
    int     e;
    int     b;
    int     sh;
    longint q;
    longint rem;
    longint half;
    r.fp  = {s, 20'h0};
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (m == 0) begin
      r.unf = 1'b1;
      return r;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = e_in + p - 24;
    if (p >= 12) begin
      sh  = p - 12;
      q   = m / (64'sd1 << sh);
      rem = m - q * (64'sd1 << sh);
      if (sh > 0) begin
        half = 64'sd1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
    end else begin
      q = m * (64'sd1 << (12 - p));
    end
    if (q == 8192) begin
      q = 4096;
      e++;
    end
    b = e + 127;
    if (b <= 0) r.unf = 1'b1;
    else if (b >= 255) begin
      r.ovf = 1'b1;
      r.fp  = {s, 8'hFF, 12'h000};
    end else begin
      r.fp = {s, 8'(b), 12'(q - 4096)};
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [20:0] fp, input logic ovf, input logic unf);
    exp_t r;
    r.fp  = fp;
    r.ovf = ovf;
    r.unf = unf;
    return r;
  endfunction

  // Downstream ready: always, fixed 1,0,0,1 pattern, or random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_cyc++;
  end

  // Monitor: compare every presented output against the queue head; pop on transfer
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          check("out_fp", 32'(out_fp), 32'(sb_q[0].fp));
          check("out_overflow", 32'(out_overflow), 32'(sb_q[0].ovf));
          check("out_underflow", 32'(out_underflow), 32'(sb_q[0].unf));
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_popped++;
          end
        end
      end
    end
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [25:0] m, input exp_t x);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mag   = m;
    while (!acc) begin
      @(negedge clk);
      acc = rst_n && in_ready;
      if (acc) sb_q.push_back(x);
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        check("send_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_rand();
    int     e;
    longint m;
    int     w;
    logic   s;
    s = 1'($urandom_range(0, 1));
    e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) - 512
                                    : int'($urandom_range(0, 280)) - 140;
    w = int'($urandom_range(0, 26));
    m = (w == 0) ? 64'sd0 : longint'($urandom) & ((64'sd1 << w) - 1);
    if ($urandom_range(0, 7) == 0) m = m | (64'sd1 << 24) | (64'sd1 << 11);
    send(s, 10'(e), 26'(m), model(s, e, m));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int popped0;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp", 32'(out_fp), 32'd0);
    check("rst_flags", 32'({out_overflow, out_underflow}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 with latency measurement on an empty pipe
    send(1'b0, 10'd0, 26'(1 << 24), mk(21'h07F000, 1'b0, 1'b0));
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 32'(cnt), 32'd3);
    wait_drain();

    // Normalisation, rounding and range corners
    send(1'b0, 10'd0,   26'(3 << 24),                        mk(21'h080800, 1'b0, 1'b0));
    send(1'b0, 10'd0,   26'(3 << 23),                        mk(21'h07F800, 1'b0, 1'b0));
    send(1'b0, 10'd14,  26'(1 << 10),                        mk(21'h07F000, 1'b0, 1'b0));
    send(1'b0, 10'd0,   26'((1 << 24) | (1 << 11)),          mk(21'h07F000, 1'b0, 1'b0));
    send(1'b0, 10'd0,   26'((1 << 24) | (1 << 12) | (1 << 11)), mk(21'h07F002, 1'b0, 1'b0));
    send(1'b0, 10'd0,   26'((1 << 25) - 1),                  mk(21'h080000, 1'b0, 1'b0));
    send(1'b1, 10'd128, 26'(1 << 24),                        mk(21'h1FF000, 1'b1, 1'b0));
    send(1'b0, 10'(-127), 26'(1 << 24),                      mk(21'h000000, 1'b0, 1'b1));
    send(1'b1, 10'd0,   26'd0,                               mk(21'h100000, 1'b0, 1'b1));
    send(1'b0, 10'd127, 26'((1 << 25) - 1),                  mk(21'h0FF000, 1'b1, 1'b0));
    wait_drain();

    // Backpressure stream of 8 beats with ready pattern 1,0,0,1
    popped0  = n_popped;
    rdy_cyc  = 0;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    wait_drain();
    check("stream_count", 32'(n_popped - popped0), 32'd8);
    rdy_mode = 0;

    // Reset with three beats in flight
    send(1'b0, 10'd1, 26'(1 << 24), mk(21'h080000, 1'b0, 1'b0));
    send(1'b0, 10'd2, 26'(1 << 24), mk(21'h081000, 1'b0, 1'b0));
    send(1'b0, 10'd3, 26'(1 << 24), mk(21'h082000, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_fp", 32'(out_fp), 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(1'b1, 10'd0, 26'(1 << 24), mk(21'h17F000, 1'b0, 1'b0));
    wait_drain();

    // Randomised traffic under random backpressure and input gaps
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    wait_drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp21_pack.md
Name: fp21_pack

Overview:
- Pipelined FP21 normalise/round/pack unit; the inverse of the FP21 unpacker.
- Takes sign, signed unbiased exponent and an unnormalised magnitude from arithmetic cores (adder, multiplier) and emits a packed 21-bit FP21 word (1 sign, 8 exp, 12 frac, bias 127).
- Sits at the output of every FP21 datapath core, ahead of register files and the ray/shading pipeline.
- Denormals are not supported; results below the normal range flush to signed zero.

Parameters:
FRAC_W, 12, stored fraction bits
EXP_W, 8, stored exponent bits
BIAS, 127, exponent bias
EXP_IN_W, 10, width of signed unbiased input exponent (two's complement)
MAG_W, 26, input magnitude width; binary point sits between bit MAG_W-2 and bit MAG_W-3 (two integer bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
in_sign  in  1  sign
in_exp  in  EXP_IN_W  signed unbiased exponent
in_mag  in  MAG_W  magnitude; value = (-1)^sign * in_mag/2^(MAG_W-2) * 2^in_exp
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_fp  out  1+EXP_W+FRAC_W  packed {sign, biased exp, frac}
out_overflow  out  1  result saturated to infinity
out_underflow  out  1  result flushed to zero (includes in_mag==0)

Behaviour:
- Reset (async, rst_n low): all stage-valid bits 0; out_valid=0, out_fp=0, out_overflow=0, out_underflow=0. Reset asserted mid-operation discards all in-flight beats; no partial result appears after release.
- Handshake: adv = !out_valid | out_ready; in_ready = adv (combinational).
  - A beat transfers on in_valid & in_ready; the output transfers on out_valid & out_ready.
  - When adv=0 the whole pipe holds; bubbles are not compressed.
  - out_fp and the flags stay stable while out_valid & !out_ready.
- Latency: 3 cycles from accepted input to out_valid when unstalled; throughput 1 beat/cycle.
- Stage 1 (LZC):
  - Register sign, exp and mag.
  - Compute p = index of the leading one of mag; zero flag if mag==0.
- Stage 2 (normalise):
  - Left-shift mag so the leading one sits at bit MAG_W-1.
  - e = in_exp + p - (MAG_W-2), evaluated at EXP_IN_W+2 bits signed, no wrap.
  - Extract frac = next FRAC_W bits, guard = following bit, sticky = OR of the remaining bits.
- Stage 3 (round/pack):
  - Round to nearest, ties to even: increment if guard & (sticky | frac[0]).
  - Fraction carry-out gives frac=0 and e+1.
  - biased = e + BIAS.
  - zero flag → {sign, 0, 0}, underflow=1.
  - biased <= 0 → {sign, 0, 0}, underflow=1.
  - biased >= 2^EXP_W-1 → {sign, all-ones, 0}, overflow=1.
  - Otherwise → {sign, biased[EXP_W-1:0], frac}, both flags 0.
- Rounding is applied before the overflow/underflow test, so a carry can push a result into overflow.
- Overflow and underflow are mutually exclusive.
- Inputs are sampled only on an accepted beat; in_* are don't-care otherwise.

Test Plan:
- 1.0: sign=0, exp=0, mag=1<<24 → out_fp=0x7F000, flags 0, out_valid exactly 3 cycles after acceptance.
- Normalisation: mag=3<<24 → 0x80800 (3.0); mag=3<<23 → 0x7F800 (1.5); mag=1<<10, exp=14 → 0x7F000.
- Rounding:
  - mag=(1<<24)|(1<<11) → 0x7F000 (tie, even down).
  - mag=(1<<24)|(1<<12)|(1<<11) → 0x7F002 (tie, up).
  - mag=(1<<25)-1 → 0x80000 (carry-out renormalise).
- Range:
  - sign=1, exp=128, mag=1<<24 → 0x1FF000, overflow=1.
  - exp=-127, mag=1<<24 → 0x00000, underflow=1.
  - sign=1, mag=0 → 0x100000, underflow=1.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,...
  - All 8 results in order, none lost or duplicated.
  - in_ready low exactly while out_valid & !out_ready.
  - out_fp is stable while stalled.
- Reset: pull rst_n low with 3 beats in flight → out_valid drops immediately; after release, out_valid stays 0 until new beats are accepted.
